// File: rtl/usb_protocol_ctrl.sv
// Bulk-endpoint transaction sequencer: decodes tokens from rcv_usb, steers the
// shared buffer, commands the transmitter and reports results to the host side.
//
// state         | meaning
// S_IDLE        | waiting for a token, receiver owns buffer
// S_OUT_WAIT    | OUT token seen, waiting for the DATA packet
// S_SEND_ACK    | transmitting ACK for accepted OUT data
// S_SEND_NAK    | transmitting NAK for an IN with no payload loaded
// S_IN_SEND     | transmitting the IN data packet
// S_IN_WAIT_HS  | IN data sent, waiting for the host handshake
module usb_protocol_ctrl #(
  parameter int TIMEOUT_CYCLES = 640,
  parameter int CNT_W          = 10
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       rx_transfer_active,
  input  logic [2:0] rx_packet,
  input  logic       rx_error,
  input  logic       tx_transfer_active,
  input  logic       tx_error,
  input  logic [6:0] buffer_occupancy,
  input  logic       tx_data_pending,
  output logic [2:0] tx_packet,
  output logic       d_mode,
  output logic       clear,
  output logic       rx_data_received,
  output logic       tx_done,
  output logic       tx_fail,
  output logic       ctrl_error
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_OUT_WAIT   = 3'd1;
  localparam logic [2:0] S_SEND_ACK   = 3'd2;
  localparam logic [2:0] S_SEND_NAK   = 3'd3;
  localparam logic [2:0] S_IN_SEND    = 3'd4;
  localparam logic [2:0] S_IN_WAIT_HS = 3'd5;

  localparam logic [2:0] PID_OUT  = 3'b001;
  localparam logic [2:0] PID_IN   = 3'b010;
  localparam logic [2:0] PID_DATA = 3'b011;
  localparam logic [2:0] PID_ACK  = 3'b100;

  localparam logic [2:0] TXP_NONE = 3'b000;
  localparam logic [2:0] TXP_DATA = 3'b001;
  localparam logic [2:0] TXP_ACK  = 3'b010;
  localparam logic [2:0] TXP_NAK  = 3'b011;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             started_q, started_d;
  logic             rx_prev_q, tx_prev_q;
  logic [2:0]       tx_packet_q, tx_packet_d;
  logic             d_mode_q, d_mode_d;
  logic             clear_q, clear_d;
  logic             rx_data_received_q, rx_data_received_d;
  logic             tx_done_q, tx_done_d;
  logic             tx_fail_q, tx_fail_d;
  logic             ctrl_error_q, ctrl_error_d;

  logic rx_end, tx_end, expired, rx_invalid, in_send, counting;

  assign rx_end     = rx_prev_q & ~rx_transfer_active;
  assign tx_end     = tx_prev_q & ~tx_transfer_active;
  assign expired    = (cnt_q == CNT_LAST);
  assign rx_invalid = (rx_packet[2:1] == 2'b11);
  assign in_send    = (state_q == S_SEND_ACK) || (state_q == S_SEND_NAK) ||
                      (state_q == S_IN_SEND);

  always_comb begin
    state_d            = state_q;
    started_d          = started_q;
    tx_packet_d        = tx_packet_q;
    clear_d            = 1'b0;
    rx_data_received_d = 1'b0;
    tx_done_d          = 1'b0;
    tx_fail_d          = 1'b0;
    ctrl_error_d       = 1'b0;
    counting           = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_end) begin
          if (rx_error || rx_invalid) begin
            ctrl_error_d = 1'b1;
          end else if (rx_packet == PID_OUT) begin
            state_d = S_OUT_WAIT;
          end else if (rx_packet == PID_IN) begin
            state_d     = tx_data_pending ? S_IN_SEND : S_SEND_NAK;
            tx_packet_d = tx_data_pending ? TXP_DATA : TXP_NAK;
          end
        end
      end
      S_OUT_WAIT: begin
        counting = ~rx_transfer_active;
        if (rx_end) begin
          // Any errored packet may have left partial bytes in the buffer.
          if (rx_error) begin
            clear_d      = 1'b1;
            ctrl_error_d = 1'b1;
            state_d      = S_IDLE;
          end else if (rx_packet == PID_DATA) begin
            state_d     = S_SEND_ACK;
            tx_packet_d = TXP_ACK;
          end else begin
            ctrl_error_d = 1'b1;
            state_d      = S_IDLE;
          end
        end else if (expired && !rx_transfer_active) begin
          ctrl_error_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      S_SEND_ACK, S_SEND_NAK, S_IN_SEND: begin
        counting = ~started_q;
        if (tx_error || (!started_q && expired)) begin
          ctrl_error_d = 1'b1;
          tx_fail_d    = (state_q == S_IN_SEND);
          tx_packet_d  = TXP_NONE;
          state_d      = S_IDLE;
        end else if (tx_end) begin
          rx_data_received_d = (state_q == S_SEND_ACK);
          state_d            = (state_q == S_IN_SEND) ? S_IN_WAIT_HS : S_IDLE;
        end else if (tx_transfer_active) begin
          started_d   = 1'b1;
          tx_packet_d = TXP_NONE;
        end
      end
      S_IN_WAIT_HS: begin
        counting = ~rx_transfer_active;
        if (rx_end) begin
          if (!rx_error && rx_packet == PID_ACK) begin
            tx_done_d = 1'b1;
            clear_d   = 1'b1;
          end else begin
            tx_fail_d = 1'b1;
          end
          state_d = S_IDLE;
        end else if (expired && !rx_transfer_active) begin
          tx_fail_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Counter restarts on entry and while a packet is still arriving.
    if (state_d != state_q) begin
      cnt_d     = '0;
      started_d = 1'b0;
    end else if (counting) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end

    d_mode_d = (state_d == S_SEND_ACK) || (state_d == S_SEND_NAK) ||
               (state_d == S_IN_SEND);
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_q            <= S_IDLE;
      cnt_q              <= '0;
      started_q          <= 1'b0;
      rx_prev_q          <= 1'b0;
      tx_prev_q          <= 1'b0;
      tx_packet_q        <= TXP_NONE;
      d_mode_q           <= 1'b0;
      clear_q            <= 1'b0;
      rx_data_received_q <= 1'b0;
      tx_done_q          <= 1'b0;
      tx_fail_q          <= 1'b0;
      ctrl_error_q       <= 1'b0;
    end else begin
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      started_q          <= started_d;
      rx_prev_q          <= rx_transfer_active;
      tx_prev_q          <= tx_transfer_active & in_send;
      tx_packet_q        <= tx_packet_d;
      d_mode_q           <= d_mode_d;
      clear_q            <= clear_d;
      rx_data_received_q <= rx_data_received_d;
      tx_done_q          <= tx_done_d;
      tx_fail_q          <= tx_fail_d;
      ctrl_error_q       <= ctrl_error_d;
    end
  end

  assign tx_packet        = tx_packet_q;
  assign d_mode           = d_mode_q;
  assign clear            = clear_q;
  assign rx_data_received = rx_data_received_q;
  assign tx_done          = tx_done_q;
  assign tx_fail          = tx_fail_q;
  assign ctrl_error       = ctrl_error_q;

  logic unused_ok;
  assign unused_ok = ^buffer_occupancy;

endmodule

// File: doc/usb_protocol_ctrl.md
Name: usb_protocol_ctrl

Overview:
- Sequences the USB device's receive and transmit paths for one bulk endpoint: decodes completed token packets from rcv_usb, steers the shared data buffer (d_mode), commands the transmitter (tx_packet) and reports transaction results to the AHB-side host interface.
- Sits between rcv_usb, the USB transmitter, the shared 64-byte data buffer and the AHB slave.
- The controller is the sole owner of d_mode and buffer clear.

Parameters:
TIMEOUT_CYCLES, 640, clocks to wait for an expected packet start or end before abandoning (about 80 bit times at 8 clk/bit)
CNT_W, 10, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  system clock, all state on rising edge
n_rst  in  1  asynchronous reset, active-high (n_rst=1 resets)
rx_transfer_active  in  1  high while rcv_usb is receiving a packet
rx_packet  in  3  last received PID class, valid at packet end: 000 none, 001 OUT, 010 IN, 011 DATA0/1, 100 ACK, 101 NAK, 11x invalid
rx_error  in  1  rcv_usb error flag for current/last packet
tx_transfer_active  in  1  high while transmitter is sending
tx_error  in  1  transmitter error
buffer_occupancy  in  7  bytes in shared buffer, 0..64
tx_data_pending  in  1  host has loaded a complete IN payload
tx_packet  out  3  transmit command: 000 none, 001 DATA, 010 ACK, 011 NAK
d_mode  out  1  1 = transmitter owns buffer/bus, 0 = receiver
clear  out  1  one-cycle buffer flush pulse
rx_data_received  out  1  one-cycle pulse: OUT data accepted and ACKed
tx_done  out  1  one-cycle pulse: IN data ACKed by host
tx_fail  out  1  one-cycle pulse: IN data not ACKed (timeout, NAK, error)
ctrl_error  out  1  one-cycle pulse: protocol error detected

Behaviour:
- Reset (n_rst=1, async): state IDLE, timeout count 0, all outputs 0. n_rst mid-transaction aborts immediately; no pulses are emitted.
- rx_end: registered falling edge of rx_transfer_active. tx_end: falling edge of tx_transfer_active. Decisions are taken on the cycle rx_end is high. Outputs are registered, so they change 1 clk later.
- Timeout counter: clears on every state entry and counts in the wait states. Expiry is count == TIMEOUT_CYCLES-1.
- IDLE: d_mode=0. On rx_end:
  - rx_error=1 or invalid PID -> ctrl_error pulse, stay IDLE.
  - OUT -> OUT_WAIT_DATA.
  - IN with tx_data_pending=1 -> IN_SEND_DATA.
  - IN with tx_data_pending=0 -> SEND_NAK.
  - Any other PID -> ignored.
- OUT_WAIT_DATA: d_mode=0. On rx_end:
  - DATA0/1 with rx_error=0 -> SEND_ACK.
  - DATA with rx_error=1 (covers overflow beyond 64 bytes) -> clear pulse, ctrl_error pulse, IDLE; no handshake is sent.
  - Other PID -> ctrl_error, IDLE.
  - Timeout with rx_transfer_active=0 -> ctrl_error, IDLE.
  - A timeout never fires while rx_transfer_active=1.
- SEND_ACK / SEND_NAK / IN_SEND_DATA (send states):
  - Entry: drive tx_packet (ACK/NAK/DATA).
  - d_mode=1 in all send states.
  - tx_packet is held until tx_transfer_active is seen high, then returns to 000.
  - On tx_end: SEND_ACK -> rx_data_received pulse, IDLE. SEND_NAK -> IDLE. IN_SEND_DATA -> IN_WAIT_HS.
  - tx_error or timeout before start -> ctrl_error, tx_fail (IN_SEND_DATA only), IDLE.
- IN_SEND_DATA with buffer_occupancy=0 at entry is a zero-length packet and is legal.
- IN_WAIT_HS: d_mode=0. On rx_end:
  - ACK with rx_error=0 -> tx_done pulse, clear pulse, IDLE.
  - NAK, error or other PID -> tx_fail pulse, IDLE; the buffer is retained for retry.
  - Timeout -> tx_fail, IDLE.
- Simultaneous events: tx_error takes priority over tx_end. rx_end with rx_error takes priority over PID decode. At most one of tx_done/tx_fail pulses per IN transaction.
- All pulses are exactly one cycle. clear never asserts while d_mode=1.

Test Plan:
- Reset: hold n_rst=1 for 2 clk mid-SEND_ACK -> every output 0 immediately; state IDLE after release; no pulses.
- OUT + DATA0 (4 bytes, no error) -> tx_packet=010 one clk after data rx_end, held until tx_transfer_active=1; d_mode=1; rx_data_received pulses once after tx_end; clear stays 0.
- IN with tx_data_pending=1, occupancy=8 -> tx_packet=001, d_mode=1. After tx_end, host ACK rx_end -> tx_done=1 for one cycle and clear=1 in the same cycle; d_mode=0.
- IN with tx_data_pending=0 -> tx_packet=011 (NAK); no tx_done/tx_fail; back to IDLE after tx_end.
- OUT + DATA with rx_error=1 (65-byte payload) -> clear pulse and ctrl_error pulse; tx_packet stays 000.
- IN data sent, no handshake for 640 clk -> tx_fail pulse at expiry, clear=0, IDLE. Invalid-PID token in IDLE -> ctrl_error pulse only.
